// File: rtl/dm_access_seq.sv
// dm_access_seq: MEM-stage sequencer for a byte-lane data memory.
// Word-crossing accesses run as two beats when DM_MISALIGN_SPLIT_EN is defined, otherwise they are rejected.
module dm_access_seq #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [31:0]   addr,
  input  logic [2:0]    DMType,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          done,
  output logic          stall,
  output logic          err,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wea,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  // Handshake: req and its fields stay stable until the cycle done=1; stall = req & ~done.
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state, state_nx;

  logic            we_q, err_q;
  logic [AW+1:0]   addr_q;
  logic [2:0]      type_q;
  logic [31:0]     wdata_q;

  function automatic logic [3:0] size_mask(input logic [2:0] t);
    case (t)
      3'd0:       size_mask = 4'b1111;
      3'd1, 3'd2: size_mask = 4'b0011;
      default:    size_mask = 4'b0001;
    endcase
  endfunction

  // Accept decision on the live request fields.
  logic [7:0] in_lanes;
  logic       in_bad;
  assign in_lanes = {4'b0000, size_mask(DMType)} << addr[1:0];
`ifdef DM_MISALIGN_SPLIT_EN
  assign in_bad = (DMType > 3'd4);
`else
  assign in_bad = (DMType > 3'd4) || (in_lanes[7:4] != 4'b0000);
`endif

  logic [1:0]  pos;
  logic [7:0]  lanes;
  logic [63:0] wide_wdata;
  logic        split;
  assign pos        = addr_q[1:0];
  assign lanes      = {4'b0000, size_mask(type_q)} << pos;
  assign wide_wdata = {32'b0, wdata_q} << {pos, 3'b000};
  assign split      = |lanes[7:4];

  logic [63:0] ld_wide;
`ifdef DM_MISALIGN_SPLIT_EN
  logic [31:0] lo_q;
  always_ff @(posedge clk) begin
    if (rst)
      lo_q <= '0;
    else if (state == BEAT1)
      lo_q <= mem_rdata;
  end
  assign ld_wide = split ? ({mem_rdata, lo_q} >> {pos, 3'b000})
                         : ({32'b0, mem_rdata} >> {pos, 3'b000});
`else
  assign ld_wide = {32'b0, mem_rdata} >> {pos, 3'b000};
`endif

  logic [31:0] ld_d, ld_ext;
  assign ld_d = ld_wide[31:0];
  always_comb begin
    case (type_q)
      3'd1:    ld_ext = {{16{ld_d[15]}}, ld_d[15:0]};
      3'd2:    ld_ext = {16'b0, ld_d[15:0]};
      3'd3:    ld_ext = {{24{ld_d[7]}}, ld_d[7:0]};
      3'd4:    ld_ext = {24'b0, ld_d[7:0]};
      default: ld_ext = ld_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      type_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr[AW+1:0];
        type_q  <= DMType;
        wdata_q <= wdata;
        err_q   <= in_bad;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wea   = 4'b0000;
    mem_wdata = '0;
    done      = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    case (state)
      IDLE: if (req) state_nx = in_bad ? RESP : BEAT0;
      BEAT0: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q[AW+1:2];
        mem_wea   = we_q ? lanes[3:0] : 4'b0000;
        mem_wdata = wide_wdata[31:0];
`ifdef DM_MISALIGN_SPLIT_EN
        state_nx  = split ? BEAT1 : RESP;
`else
        state_nx  = RESP;
`endif
      end
`ifdef DM_MISALIGN_SPLIT_EN
      BEAT1: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q[AW+1:2] + AW'(1);
        mem_wea   = we_q ? lanes[7:4] : 4'b0000;
        mem_wdata = wide_wdata[63:32];
        state_nx  = RESP;
      end
`endif
      RESP: begin
        done     = 1'b1;
        err      = err_q;
        rdata    = (we_q || err_q) ? 32'b0 : ld_ext;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign stall = req & ~done;

  // Bits that only matter in one build configuration, or not at all.
  logic unused;
  assign unused = ^{addr[31:AW+2], in_lanes[3:0], lanes[7:4], wide_wdata[63:32], split, ld_wide[63:32]};
endmodule

// File: tb/tb_dm_access_seq.sv
// Bench for dm_access_seq: directed cases plus randomized accesses against a byte-array memory model.
`timescale 1ns/1ps
module tb_dm_access_seq;
  localparam int AW = 10;
  localparam int NW = 1 << AW;
  localparam int NB = NW * 4;
`ifdef DM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, req, we;
  logic [31:0]   addr, wdata, rdata, mem_wdata, mem_rdata;
  logic [2:0]    dm_type;
  logic          done, stall, err, mem_en;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wea;

  dm_access_seq #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .DMType(dm_type),
    .wdata(wdata), .rdata(rdata), .done(done), .stall(stall), .err(err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wea(mem_wea),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- memory attached to the DUT (synchronous read) and reference byte memory ----
  logic [31:0] dmem [NW];
  logic [7:0]  rmem [NB];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= dmem[mem_addr];
      for (int k = 0; k < 4; k++)
        if (mem_wea[k]) dmem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  function automatic logic [31:0] ref_word(input int i);
    return {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
  endfunction

  task automatic set_word(input int i, input logic [31:0] v);
    dmem[i] <= v;
    for (int k = 0; k < 4; k++) rmem[4*i+k] = v[8*k +: 8];
  endtask

  // ---- scoreboard ----
  int total = 0;
  int bad = 0;
  logic [AW-1:0]   exp_q[$];
  logic [AW+35:0]  beat_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_en) begin
      beat_log.push_back({mem_addr, mem_wea, mem_wdata});
      if (exp_q.size() == 0) check("beat_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
      else check("beat_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
    end
  end

  // ---- driver: one access, checked against the byte-level model ----
  task automatic run(input logic w, input logic [31:0] a, input logic [2:0] t,
                     input logic [31:0] wd, output logic [31:0] got_r);
    int size, pos, lat, cyc;
    logic spl, rej;
    logic [31:0] v, exp_r;
    logic [AW-1:0] wa;
    size  = (t == 3'd0) ? 4 : (t <= 3'd2) ? 2 : 1;
    pos   = int'(a[1:0]);
    spl   = (pos + size) > 4;
    rej   = (t > 3'd4) || (spl && !SPLIT_ON);
    wa    = a[AW+1:2];
    lat   = rej ? 1 : (spl ? 3 : 2);
    exp_r = 32'b0;
    v     = 32'b0;
    if (!rej) begin
      exp_q.push_back(wa);
      if (spl) exp_q.push_back(wa + AW'(1));
      for (int k = 0; k < size; k++) begin
        int b;
        b = (int'(a[AW+1:0]) + k) % NB;
        if (w) rmem[b] = wd[8*k +: 8];
        else v[8*k +: 8] = rmem[b];
      end
      if (!w) begin
        case (t)
          3'd1:    exp_r = {{16{v[15]}}, v[15:0]};
          3'd2:    exp_r = {16'b0, v[15:0]};
          3'd3:    exp_r = {{24{v[7]}}, v[7:0]};
          3'd4:    exp_r = {24'b0, v[7:0]};
          default: exp_r = v;
        endcase
      end
    end

    @(negedge clk);
    req = 1'b1; we = w; addr = a; dm_type = t; wdata = wd;
    #1 check("stall_req", {31'b0, stall}, 32'd1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        check("stall_wait", {31'b0, stall}, 32'd1);
        check("rdata_idle", rdata, 32'd0);
      end
    end while (!done && cyc < 8);
    got_r = rdata;
    check("latency", cyc, lat);
    check("stall_done", {31'b0, stall}, 32'd0);
    check("err", {31'b0, err}, {31'b0, rej});
    check("rdata", rdata, exp_r);
    req = 1'b0;
    check("beats_left", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Store word interrupted by reset during its first beat.
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] wd);
    logic [AW-1:0] wa;
    int pos;
    wa  = a[AW+1:2];
    pos = int'(a[1:0]);
    beat_log.delete();
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; dm_type = 3'd0; wdata = wd;
    exp_q.push_back(wa);
    @(negedge clk);
    check("rm_beat0", {31'b0, mem_en}, 32'd1);
    rst = 1'b1;
    for (int k = 0; k < 4 - pos; k++) rmem[4*int'(wa)+pos+k] = wd[8*k +: 8];
    @(negedge clk);
    check("rm_done", {31'b0, done}, 32'd0);
    check("rm_err", {31'b0, err}, 32'd0);
    check("rm_mem_en", {31'b0, mem_en}, 32'd0);
    check("rm_wea", {28'b0, mem_wea}, 32'd0);
    check("rm_wdata", mem_wdata, 32'd0);
    check("rm_addr", 32'(mem_addr), 32'd0);
    check("rm_rdata", rdata, 32'd0);
    req = 1'b0;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rm_quiet_done", {31'b0, done}, 32'd0);
      check("rm_quiet_en", {31'b0, mem_en}, 32'd0);
    end
    check("rm_beats", beat_log.size(), 32'd1);
    check("rm_word", dmem[wa], ref_word(int'(wa)));
    check("rm_word_next", dmem[wa + AW'(1)], ref_word(int'(wa + AW'(1))));
    exp_q.delete();
  endtask

  // ---- stimulus ----
  initial begin
    logic [31:0] r;
    logic [AW+35:0] e;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; dm_type = '0; wdata = '0;
    for (int i = 0; i < NW; i++) set_word(i, $urandom);
    repeat (3) @(negedge clk);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_wea", {28'b0, mem_wea}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    req = 1'b1;
    #1 check("rst_stall_hi", {31'b0, stall}, 32'd1);
    req = 1'b0;
    #1 check("rst_stall_lo", {31'b0, stall}, 32'd0);
    rst = 1'b0;

    beat_log.delete();
    run(1'b1, 32'h8, 3'd0, 32'hDEADBEEF, r);
    e = beat_log[0];
    check("sw_nbeats", beat_log.size(), 32'd1);
    check("sw_addr", 32'(e[AW+35:36]), 32'd2);
    check("sw_wea", {28'b0, e[35:32]}, 32'hF);
    check("sw_wdata", e[31:0], 32'hDEADBEEF);

    set_word(1, 32'h80012233);
    beat_log.delete();
    run(1'b0, 32'h6, 3'd1, 32'h0, r);
    e = beat_log[0];
    check("lh_addr", 32'(e[AW+35:36]), 32'd1);
    check("lh_wea", {28'b0, e[35:32]}, 32'd0);
    check("lh_rdata", r, 32'hFFFF8001);

`ifdef DM_MISALIGN_SPLIT_EN
    beat_log.delete();
    run(1'b1, 32'h5, 3'd0, 32'h11223344, r);
    check("ssw_nbeats", beat_log.size(), 32'd2);
    e = beat_log[0];
    check("ssw_addr0", 32'(e[AW+35:36]), 32'd1);
    check("ssw_wea0", {28'b0, e[35:32]}, 32'hE);
    check("ssw_wdata0", e[31:0], 32'h22334400);
    e = beat_log[1];
    check("ssw_addr1", 32'(e[AW+35:36]), 32'd2);
    check("ssw_wea1", {28'b0, e[35:32]}, 32'h1);
    check("ssw_wdata1", e[31:0], 32'h00000011);
    set_word(1, 32'hAABBCCDD);
    set_word(2, 32'h11223344);
    run(1'b0, 32'h7, 3'd0, 32'h0, r);
    check("slw_rdata", r, 32'h223344AA);
    run(1'b0, 32'h7, 3'd4, 32'h0, r);
    check("lbu_rdata", r, 32'h000000AA);
    run(1'b0, 32'hFFE, 3'd0, 32'h0, r);
    reset_mid(32'h5, 32'h11223344);
`else
    beat_log.delete();
    run(1'b1, 32'h5, 3'd0, 32'h11223344, r);
    check("rej_split_beats", beat_log.size(), 32'd0);
    check("rej_split_mem", dmem[1], ref_word(1));
    reset_mid(32'h10, 32'h11223344);
`endif
    beat_log.delete();
    run(1'b0, 32'h20, 3'd7, 32'h0, r);
    check("rej_type_beats", beat_log.size(), 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [2:0] t;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[AW+1:2] = '1;
      t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      run(1'($urandom_range(0, 1)), a, t, $urandom, r);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < NW; i++) check("mem_word", dmem[i], ref_word(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
